serial_transmitter: RTL and testbench
=====================================

Name: serial_transmitter

Overview:
- Push-button-clocked serial framer. Each press of `ClkPB` is converted to a single-`clk` step pulse.
- On each step, one bit of `SerIn` is consumed. A frame is a 0 start bit, then a 4-bit length N (MSB first), then N payload bits.
- Payload bits are forwarded to `SerOut` with `SerOutValid` high.
- A 7-segment display shows the remaining payload count in hex.
- Sits between board switches/buttons and a downstream serial consumer; also drives a board LED digit.

Parameters:
- CNT_W, 4, width of the length field and the remaining-count register (max N = 2^CNT_W-1).
- SYNC_STAGES, 2, flip-flop stages synchronising `ClkPB` into the `clk` domain.
- DEBOUNCE_CYCLES, 4, consecutive `clk` cycles the synchronised `ClkPB` must be stable high before a step is accepted (used only with DEBOUNCE_EN).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous active-low reset.
- SerIn  input  1  serial data, sampled on step cycles only.
- ClkPB  input  1  push-button step request, asynchronous, active-high.
- SerOut  output  1  forwarded payload bit: equals `SerIn` while in TRANSMIT, else 0 (combinational).
- SerOutValid  output  1  high exactly while in TRANSMIT (registered state decode).
- seven_segments  output  7  active-low hex digit of the count register; bit0=a … bit6=g.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; count=0; bit index=0; sync and edge registers=0.
  - Outputs: `SerOutValid`=0, `SerOut`=0, `seven_segments`=7'b1000000 ("0").
- Step pulse:
  - `ClkPB` passes through SYNC_STAGES flops, then a rising-edge detect.
  - step = 1 for exactly one `clk` cycle per 0→1 transition of the synchronised button.
  - Holding the button yields no further steps.
  - Latency from `ClkPB` rise to step high: SYNC_STAGES+1 clk edges.
- All state changes occur only on clk edges where step=1; otherwise every register holds.
- FSM, evaluated on step:
  - IDLE: if `SerIn`=0 → LOAD, clear count and bit index. If `SerIn`=1, stay in IDLE.
  - LOAD: `count` ← {`count`[CNT_W-2:0], `SerIn`} and the bit index increments. When CNT_W bits have been taken, the next state is TRANSMIT if the assembled value ≠ 0, else IDLE.
  - TRANSMIT: each step consumes one payload bit and decrements `count`. When `count` reaches 0, return to IDLE on that same step. A new start bit is required to begin the next frame.
- `SerOut`/`SerOutValid`: in TRANSMIT, `SerOut`=`SerIn` combinationally; downstream samples on step cycles. Exactly N step cycles occur with `SerOutValid`=1 per frame.
- `seven_segments` decodes `count` (low 4 bits):
  - Standard hex glyphs 0–F, active-low.
  - Updates during LOAD as bits shift in.
  - Shows the remaining count during TRANSMIT; shows 0 after completion.
  - Holds its value in IDLE.
- Boundaries:
  - Length 0: no TRANSMIT entry; `SerOutValid` never asserts.
  - Button pressed while rst=0: ignored; edge detector is cleared, so no spurious step occurs after release of reset.
  - Reset mid-frame aborts immediately to IDLE with count=0.

Optional Feature:
- DEBOUNCE_EN defined:
  - The synchronised `ClkPB` must stay high for DEBOUNCE_CYCLES consecutive `clk` cycles before step fires (once).
  - The button must then go low for DEBOUNCE_CYCLES before re-arming.
  - Step latency becomes SYNC_STAGES+DEBOUNCE_CYCLES+1 clk edges.
- Undefined: the raw synchronised edge detect described above; glitches produce extra steps.

Test Plan:
- Reset: rst=0 with random inputs → `SerOutValid`=0, `SerOut`=0, `seven_segments`=7'b1000000. Release rst → no step without a new `ClkPB` edge.
- Step generation: hold `ClkPB` high 20 clk cycles → exactly one step; FSM advances by one bit only.
- Frame N=3: steps with `SerIn` = 0,0,0,1,1, then payload 1,0,1 → LOAD count display 0,0,1,3. `SerOutValid`=1 for 3 steps; `SerOut` samples 1,0,1; display 3,2,1,0; then IDLE.
- Length 0: `SerIn` = 0,0,0,0,0 → returns to IDLE; `SerOutValid` stays 0; display 0.
- Idle line: `SerIn`=1 for 10 steps → stays IDLE, outputs unchanged. Then a frame with N=15 (`SerIn` 0,1,1,1,1) → 15 valid steps, display F counting down to 0.
- Mid-frame reset: assert rst during TRANSMIT with count=5 → immediate `SerOutValid`=0, display 0. Next step with `SerIn`=1 stays IDLE.

Source files
------------

// File: rtl/serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : serial_transmitter
// Brief    : Push-button stepped serial framer (start bit, CNT_W-bit length,
//            payload) with a hex 7-segment display of the count register.
//            Define DEBOUNCE_EN to require a stable button before each step.
// Revision : 1.0 - initial release
// ============================================================================
module serial_transmitter #(
    parameter int CNT_W           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SerIn,
    input  logic       ClkPB,
    output logic       SerOut,
    output logic       SerOutValid,
    output logic [6:0] seven_segments
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_TRANSMIT = 2'd2
    } state_t;

    localparam int              IDX_W    = (CNT_W > 2) ? $clog2(CNT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pb_sync;
    logic                   step;

    assign pb_sync = sync_q[SYNC_STAGES-1];

    generate
        if (SYNC_STAGES > 1) begin : g_sync_chain
            assign sync_d = {sync_q[SYNC_STAGES-2:0], ClkPB};
        end else begin : g_sync_single
            assign sync_d = ClkPB;
        end
    endgenerate

`ifdef DEBOUNCE_EN
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE_CYCLES);

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_level_q, db_level_d;

    // The accepted level flips only after the input disagrees with it for
    // DEBOUNCE_CYCLES cycles in a row; a step fires on the low-to-high flip.
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        step       = 1'b0;
        if (pb_sync != db_level_q) begin
            if (db_cnt_q == DB_FULL) begin
                db_level_d = pb_sync;
                step       = pb_sync;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
        end
    end
`else
    logic edge_q, edge_d;

    always_comb begin
        edge_d = pb_sync;
        step   = pb_sync & ~edge_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            edge_q <= edge_d;
        end
    end
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   count_shift;

    assign count_shift = {count_q[CNT_W-2:0], SerIn};

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bit_idx_d = bit_idx_q;
        if (step) begin
            case (state_q)
                S_IDLE: begin
                    if (!SerIn) begin
                        state_d   = S_LOAD;
                        count_d   = '0;
                        bit_idx_d = '0;
                    end
                end
                S_LOAD: begin
                    count_d   = count_shift;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        state_d   = (count_shift != '0) ? S_TRANSMIT : S_IDLE;
                    end
                end
                S_TRANSMIT: begin
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_ONE) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign SerOutValid = (state_q == S_TRANSMIT);
    assign SerOut      = SerOutValid & SerIn;

    logic [3:0] nibble;

    generate
        if (CNT_W >= 4) begin : g_nib_full
            assign nibble = count_q[3:0];
        end else begin : g_nib_pad
            assign nibble = {{(4-CNT_W){1'b0}}, count_q};
        end
    endgenerate

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    always_comb begin
        seven_segments = 7'b1111111;
        case (nibble)
            4'h0: seven_segments = 7'b1000000;
            4'h1: seven_segments = 7'b1111001;
            4'h2: seven_segments = 7'b0100100;
            4'h3: seven_segments = 7'b0110000;
            4'h4: seven_segments = 7'b0011001;
            4'h5: seven_segments = 7'b0010010;
            4'h6: seven_segments = 7'b0000010;
            4'h7: seven_segments = 7'b1111000;
            4'h8: seven_segments = 7'b0000000;
            4'h9: seven_segments = 7'b0010000;
            4'hA: seven_segments = 7'b0001000;
            4'hB: seven_segments = 7'b0000011;
            4'hC: seven_segments = 7'b1000110;
            4'hD: seven_segments = 7'b0100001;
            4'hE: seven_segments = 7'b0000110;
            4'hF: seven_segments = 7'b0001110;
            default: seven_segments = 7'b1111111;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_transmitter
// Brief    : Directed self-checking bench for serial_transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_transmitter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       SerIn = 1'b0;
    logic       ClkPB = 1'b0;
    logic       SerOut;
    logic       SerOutValid;
    logic [6:0] seven_segments;

    int checks = 0;
    int errors = 0;

    serial_transmitter dut (
        .clk           (clk),
        .rst           (rst),
        .SerIn         (SerIn),
        .ClkPB         (ClkPB),
        .SerOut        (SerOut),
        .SerOutValid   (SerOutValid),
        .seven_segments(seven_segments)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    // One button press; out/vld are sampled while the step pulse is high.
    task automatic do_step(input logic b, output logic out, output logic vld);
        @(negedge clk);
        SerIn = b;
        ClkPB = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        out = SerOut;
        vld = SerOutValid;
        repeat (3) @(negedge clk);
        ClkPB = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            SerIn = 1'($urandom);
            ClkPB = 1'($urandom);
            #1;
            checks++; if (SerOutValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", SerOutValid); end
            checks++; if (SerOut !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected 0", SerOut); end
            checks++; if (seven_segments !== glyph(0)) begin errors++; $display("FAIL reset_seg: got %b expected %b", seven_segments, glyph(0)); end
        end
        ClkPB = 1'b0;
        SerIn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (SerOutValid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", SerOutValid); end
        checks++; if (seven_segments !== glyph(0)) begin errors++; $display("FAIL post_reset_seg: got %b expected %b", seven_segments, glyph(0)); end
    endtask

    task automatic test_step_hold();
        logic out, vld;
        pulse_reset();
        @(negedge clk);
        SerIn = 1'b0;
        ClkPB = 1'b1;
        repeat (3) @(negedge clk);
        // Any extra step during the hold would shift a 1 into the count.
        SerIn = 1'b1;
        repeat (17) @(negedge clk);
        ClkPB = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (seven_segments !== glyph(0)) begin errors++; $display("FAIL hold_seg: got %b expected %b", seven_segments, glyph(0)); end
        do_step(1'b1, out, vld);
        checks++; if (seven_segments !== glyph(1)) begin errors++; $display("FAIL hold_next_seg: got %b expected %b", seven_segments, glyph(1)); end
        pulse_reset();
    endtask

    task automatic test_frame_n3();
        logic out, vld;
        logic [3:0] len_bits = 4'b0011;
        int         len_disp [4] = '{0, 0, 1, 3};
        logic [2:0] pay_bits = 3'b101;
        do_step(1'b1, out, vld);
        checks++; if (out !== 1'b0 || vld !== 1'b0) begin errors++; $display("FAIL idle_gate: got out=%b vld=%b expected 0 0", out, vld); end
        do_step(1'b0, out, vld);
        for (int i = 0; i < 4; i++) begin
            do_step(len_bits[3-i], out, vld);
            checks++; if (vld !== 1'b0) begin errors++; $display("FAIL n3_load_vld[%0d]: got %b expected 0", i, vld); end
            checks++; if (seven_segments !== glyph(len_disp[i])) begin errors++; $display("FAIL n3_load_seg[%0d]: got %b expected %b", i, seven_segments, glyph(len_disp[i])); end
        end
        checks++; if (SerOutValid !== 1'b1) begin errors++; $display("FAIL n3_enter_tx: got %b expected 1", SerOutValid); end
        for (int i = 0; i < 3; i++) begin
            do_step(pay_bits[2-i], out, vld);
            checks++; if (vld !== 1'b1 || out !== pay_bits[2-i]) begin errors++; $display("FAIL n3_payload[%0d]: got out=%b vld=%b expected out=%b vld=1", i, out, vld, pay_bits[2-i]); end
            checks++; if (seven_segments !== glyph(2-i)) begin errors++; $display("FAIL n3_tx_seg[%0d]: got %b expected %b", i, seven_segments, glyph(2-i)); end
        end
        checks++; if (SerOutValid !== 1'b0) begin errors++; $display("FAIL n3_done_vld: got %b expected 0", SerOutValid); end
    endtask

    task automatic test_length_zero();
        logic out, vld;
        for (int i = 0; i < 5; i++) begin
            do_step(1'b0, out, vld);
            checks++; if (vld !== 1'b0) begin errors++; $display("FAIL len0_vld[%0d]: got %b expected 0", i, vld); end
        end
        checks++; if (SerOutValid !== 1'b0) begin errors++; $display("FAIL len0_end_vld: got %b expected 0", SerOutValid); end
        checks++; if (seven_segments !== glyph(0)) begin errors++; $display("FAIL len0_seg: got %b expected %b", seven_segments, glyph(0)); end
    endtask

    task automatic test_idle_line_n15();
        logic out, vld;
        logic [3:0] len_bits = 4'b1111;
        int         len_disp [4] = '{1, 3, 7, 15};
        for (int i = 0; i < 10; i++) begin
            do_step(1'b1, out, vld);
            checks++; if (vld !== 1'b0 || out !== 1'b0) begin errors++; $display("FAIL idle_line[%0d]: got out=%b vld=%b expected 0 0", i, out, vld); end
        end
        checks++; if (seven_segments !== glyph(0)) begin errors++; $display("FAIL idle_line_seg: got %b expected %b", seven_segments, glyph(0)); end
        do_step(1'b0, out, vld);
        for (int i = 0; i < 4; i++) begin
            do_step(len_bits[3-i], out, vld);
            checks++; if (seven_segments !== glyph(len_disp[i])) begin errors++; $display("FAIL n15_load_seg[%0d]: got %b expected %b", i, seven_segments, glyph(len_disp[i])); end
        end
        for (int i = 0; i < 15; i++) begin
            logic b;
            b = 1'(i % 2);
            do_step(b, out, vld);
            checks++; if (vld !== 1'b1 || out !== b) begin errors++; $display("FAIL n15_payload[%0d]: got out=%b vld=%b expected out=%b vld=1", i, out, vld, b); end
            checks++; if (seven_segments !== glyph(14-i)) begin errors++; $display("FAIL n15_seg[%0d]: got %b expected %b", i, seven_segments, glyph(14-i)); end
        end
        checks++; if (SerOutValid !== 1'b0) begin errors++; $display("FAIL n15_done_vld: got %b expected 0", SerOutValid); end
    endtask

    task automatic test_midframe_reset();
        logic out, vld;
        logic [3:0] len_bits = 4'b0111;
        do_step(1'b0, out, vld);
        for (int i = 0; i < 4; i++) do_step(len_bits[3-i], out, vld);
        do_step(1'b1, out, vld);
        do_step(1'b1, out, vld);
        checks++; if (seven_segments !== glyph(5) || SerOutValid !== 1'b1) begin errors++; $display("FAIL mid_pre: got seg=%b vld=%b expected seg=%b vld=1", seven_segments, SerOutValid, glyph(5)); end
        @(negedge clk);
        SerIn = 1'b1;
        rst = 1'b0;
        #1;
        checks++; if (SerOutValid !== 1'b0 || SerOut !== 1'b0) begin errors++; $display("FAIL mid_abort: got vld=%b out=%b expected 0 0", SerOutValid, SerOut); end
        checks++; if (seven_segments !== glyph(0)) begin errors++; $display("FAIL mid_abort_seg: got %b expected %b", seven_segments, glyph(0)); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        do_step(1'b1, out, vld);
        checks++; if (vld !== 1'b0 || seven_segments !== glyph(0)) begin errors++; $display("FAIL mid_idle: got vld=%b seg=%b expected 0 %b", vld, seven_segments, glyph(0)); end
        do_step(1'b0, out, vld);
        for (int i = 0; i < 3; i++) do_step(1'b0, out, vld);
        do_step(1'b1, out, vld);
        do_step(1'b1, out, vld);
        checks++; if (vld !== 1'b1 || out !== 1'b1) begin errors++; $display("FAIL mid_n1_payload: got out=%b vld=%b expected 1 1", out, vld); end
        checks++; if (SerOutValid !== 1'b0) begin errors++; $display("FAIL mid_n1_done: got %b expected 0", SerOutValid); end
    endtask

    initial begin
        test_reset();
        test_step_hold();
        test_frame_n3();
        test_length_zero();
        test_idle_line_n15();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
